// File: rtl/scnn_div_pkg.sv
// Shared definitions for the divider pipeline and its inverse, the index linearizer.
//   MAX_NUM_K   : largest channel count carried through the pipeline
//   KW          : channel tag width used by both divider and linearizer
//   lin_state_t : linearizer FSM states
//   lin_cnt_w() : step counter width for an M-step multiply
package scnn_div_pkg;

  localparam int unsigned MAX_NUM_K = 8;
  localparam int unsigned KW        = $clog2(MAX_NUM_K) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lin_state_t;

  // A one-step multiply still needs a 1-bit counter.
  function automatic int unsigned lin_cnt_w(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/shift_add_step.sv
// One combinational shift-add multiply step.
//   i_acc / i_mcand / i_mplier : current accumulator, multiplicand, multiplier
//   o_acc / o_mcand / o_mplier : values after this step
module shift_add_step #(
  parameter int unsigned AW = 9,
  parameter int unsigned MW = 4
) (
  input  logic [AW-1:0] i_acc,
  input  logic [AW-1:0] i_mcand,
  input  logic [MW-1:0] i_mplier,
  output logic [AW-1:0] o_acc,
  output logic [AW-1:0] o_mcand,
  output logic [MW-1:0] o_mplier
);

  // Add the multiplicand when the current multiplier LSB is set.
  assign o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
  assign o_mcand  = i_mcand << 1;
  assign o_mplier = i_mplier >> 1;

endmodule

// File: rtl/index_linearizer.sv
// Recombines (quotient, divisor, remainder) into index = quotient*divisor + remainder
// using an M-cycle sequential shift-add multiply seeded with the remainder.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : request handshake (ready only in IDLE)
//   quotient, divisor,
//   remainder, k_in          : operands and channel tag
//   out_valid / out_ready    : result handshake (valid only in DONE)
//   index, err, k_out        : result, remainder>=divisor flag, captured tag
module index_linearizer
  import scnn_div_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-M:0]     quotient,
  input  logic [M-1:0]     divisor,
  input  logic [M-1:0]     remainder,
  input  logic [KW-1:0]    k_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:0]       index,
  output logic             err,
  output logic [KW-1:0]    k_out
);

  localparam int unsigned IW = N + 1;
  localparam int unsigned CW = lin_cnt_w(M);

  lin_state_t      r_state;
  lin_state_t      w_next_state;

  logic [IW-1:0]   r_acc;
  logic [IW-1:0]   r_mcand;
  logic [M-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic [KW-1:0]   r_k;

  logic [IW-1:0]   w_step_acc;
  logic [IW-1:0]   w_step_mcand;
  logic [M-1:0]    w_step_mplier;
  logic            w_last_step;

  assign w_last_step = (r_cnt == CW'(M - 1));

  // Single shared multiply step, applied once per BUSY cycle.
  shift_add_step #(
    .AW (IW),
    .MW (M)
  ) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .o_acc    (w_step_acc),
    .o_mcand  (w_step_mcand),
    .o_mplier (w_step_mplier)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and state-decoded outputs; results are gated to zero outside DONE.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    index        = '0;
    err          = 1'b0;
    k_out        = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = BUSY;
      end
      BUSY: begin
        if (w_last_step) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        index     = r_acc;
        err       = r_err;
        k_out     = r_k;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture and multiply datapath; held untouched through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_k      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            // Seeding acc with the remainder folds the final add into the multiply.
            r_acc    <= IW'(remainder);
            r_mcand  <= IW'(quotient);
            r_mplier <= divisor;
            r_cnt    <= '0;
            r_err    <= (remainder >= divisor);
            r_k      <= k_in;
          end
        end
        BUSY: begin
          r_acc    <= w_step_acc;
          r_mcand  <= w_step_mcand;
          r_mplier <= w_step_mplier;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
